reg_select_sequencer: RTL

Parametrised successor to the register select/encode logic. Latches the instruction word and extracts the opcode, Ra/Rb/Rc fields and the sign-extended C constant. Drives one-hot register-file IN/OUT enables either from manual Gra/Grb/Grc strobes or from a built-in operand-fetch/write-back sequencer. Sits between the control unit and the register file.

---
 rtl/reg_select_sequencer_pkg.sv | 35 +++
 rtl/reg_select_sequencer_onehot.sv | 32 +++
 rtl/reg_select_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reg_select_sequencer_pkg.sv
// Shared types and helpers for the register select / operand sequencer.
//   seq_state_e : sequencer state encoding
//   MODE_*      : seq_mode values
//   DEF_*_LSB   : default Ra/Rb/Rc field positions in the instruction word
//   onehot()    : index -> one-hot vector, all-zero when idx >= nregs
package reg_select_sequencer_pkg;

  localparam int MAX_REGS = 16;

  localparam int DEF_RA_LSB = 23;
  localparam int DEF_RB_LSB = 19;
  localparam int DEF_RC_LSB = 15;

  localparam logic [1:0] MODE_RD_B       = 2'd0;
  localparam logic [1:0] MODE_RD_BC      = 2'd1;
  localparam logic [1:0] MODE_RD_BC_WR_A = 2'd2;
  localparam logic [1:0] MODE_WR_A       = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_B,
    S_RD_C,
    S_WR_A,
    S_DONE
  } seq_state_e;

  function automatic logic [MAX_REGS-1:0] onehot(input logic [31:0] idx,
                                                 input logic [31:0] nregs);
    logic [MAX_REGS-1:0] v;
    v = '0;
    if (idx < nregs && idx < 32'(MAX_REGS)) v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_select_sequencer_onehot.sv
// reg_onehot_decoder: register index to one-hot enable.
//   i_idx    : register index
//   i_en     : drive the one-hot output (otherwise all zero)
//   o_onehot : one-hot enable, zero when disabled or index out of range
//   o_oor    : index >= NUM_REGS (independent of i_en)
module reg_onehot_decoder
  import reg_select_sequencer_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 16
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot,
  output logic                o_oor
);

  logic [MAX_REGS-1:0] w_full;

  assign w_full   = onehot(32'(i_idx), 32'(NUM_REGS));
  assign o_oor    = 32'(i_idx) >= 32'(NUM_REGS);
  assign o_onehot = i_en ? w_full[NUM_REGS-1:0] : '0;

  // Upper positions are always zero for smaller register files.
  generate
    if (NUM_REGS < MAX_REGS) begin : g_spare
      logic w_spare_unused;
      assign w_spare_unused = |w_full[MAX_REGS-1:NUM_REGS];
    end
  endgenerate

endmodule

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: instruction register, field extraction and
// register-file IN/OUT enable generation.
//   clock, clear          : clock, async active-low reset
//   ir_load, ir_in        : IR capture (only while IDLE)
//   Gra/Grb/Grc           : manual field selects (priority Gra > Grb > Grc)
//   Rin/Rout/BAout        : manual direction strobes
//   seq_start, seq_mode   : start the operand-fetch / write-back sequencer
//   wb_ready              : write-back data valid, gates the WR_A step
//   IN, OUT               : one-hot register write / read enables
//   ba_zero               : BAout on R0, bus must drive zero
//   opcode, C_sign_extended : decoded IR fields
//   seq_busy, seq_done, sel_err : sequencer status and select error
module reg_select_sequencer
  import reg_select_sequencer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int OPC_W    = 5,
  parameter int RA_LSB   = DEF_RA_LSB,
  parameter int RB_LSB   = DEF_RB_LSB,
  parameter int RC_LSB   = DEF_RC_LSB,
  parameter int C_W      = 19
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_load,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                seq_start,
  input  logic [1:0]          seq_mode,
  input  logic                wb_ready,
  output logic [NUM_REGS-1:0] IN,
  output logic [NUM_REGS-1:0] OUT,
  output logic                ba_zero,
  output logic [OPC_W-1:0]    opcode,
  output logic [DATA_W-1:0]   C_sign_extended,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                sel_err
);

  logic [DATA_W-1:0] r_ir;
  seq_state_e        r_state;
  logic [1:0]        r_mode;
  logic [IDX_W-1:0]  r_ra, r_rb, r_rc;

  logic [IDX_W-1:0] w_ra, w_rb, w_rc, w_man_idx;
  logic [IDX_W-1:0] w_in_idx, w_out_idx;
  logic w_busy, w_any, w_multi, w_ba_zero;
  logic w_rd, w_wr, w_in_en, w_out_en, w_in_oor, w_out_oor;

  // IR field decode
  assign w_ra   = r_ir[RA_LSB +: IDX_W];
  assign w_rb   = r_ir[RB_LSB +: IDX_W];
  assign w_rc   = r_ir[RC_LSB +: IDX_W];
  assign opcode = r_ir[DATA_W-1 -: OPC_W];
  assign C_sign_extended = {{(DATA_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};

  // Manual select
  assign w_any     = Gra | Grb | Grc;
  assign w_multi   = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign w_man_idx = Gra ? w_ra : (Grb ? w_rb : w_rc);

  assign w_busy = (r_state != S_IDLE);
  assign w_rd   = (r_state == S_RD_B) | (r_state == S_RD_C);
  assign w_wr   = (r_state == S_WR_A);

  // BAout on R0 reads the constant zero instead of a register.
  assign w_ba_zero = ~w_busy & w_any & BAout & ~Rout & (w_man_idx == '0);

  // While busy the sequencer owns both decoders and the strobes are ignored.
  // IN in WR_A follows wb_ready within the same cycle so the write lands in
  // the cycle the data is valid.
  assign w_in_idx  = w_busy ? r_ra : w_man_idx;
  assign w_in_en   = w_busy ? (w_wr & wb_ready) : (w_any & Rin);
  assign w_out_idx = w_busy ? ((r_state == S_RD_B) ? r_rb : r_rc) : w_man_idx;
  assign w_out_en  = w_busy ? w_rd : (w_any & (Rout | BAout) & ~w_ba_zero);

  reg_onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_in_dec (
    .i_idx    (w_in_idx),
    .i_en     (w_in_en),
    .o_onehot (IN),
    .o_oor    (w_in_oor)
  );

  reg_onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_out_dec (
    .i_idx    (w_out_idx),
    .i_en     (w_out_en),
    .o_onehot (OUT),
    .o_oor    (w_out_oor)
  );

  // Both decoders see the same manual index while idle, so either oor works.
  assign sel_err  = w_busy ? ((w_rd & w_out_oor) | (w_wr & w_in_oor))
                           : (w_multi | (w_any & w_out_oor));
  assign ba_zero  = w_ba_zero;
  assign seq_busy = w_busy;
  assign seq_done = (r_state == S_DONE);

  // IR, latched indices and sequencer state
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_ir    <= '0;
      r_state <= S_IDLE;
      r_mode  <= MODE_RD_B;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ir_load) r_ir <= ir_in;
          if (seq_start) begin
            // Indices come from the IR as it stood before any same-cycle load.
            r_ra    <= w_ra;
            r_rb    <= w_rb;
            r_rc    <= w_rc;
            r_mode  <= seq_mode;
            r_state <= (seq_mode == MODE_WR_A) ? S_WR_A : S_RD_B;
          end
        end
        S_RD_B:  r_state <= (r_mode == MODE_RD_B) ? S_DONE : S_RD_C;
        S_RD_C:  r_state <= (r_mode == MODE_RD_BC_WR_A) ? S_WR_A : S_DONE;
        S_WR_A:  if (wb_ready) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
